// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared funct3 size codes, access FSM states and size decoding
//            for the MEM-stage data-memory access controller.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    // Unlisted funct3 encodings fall back to a full-word access.
    function automatic size_t f3_size(input logic [2:0] f3);
        size_t sz;
        case (f3)
            F3_B, F3_BU: sz = SZ_B;
            F3_H, F3_HU: sz = SZ_H;
            default:     sz = SZ_W;
        endcase
        return sz;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_load_align
// Purpose  : Selects the addressed byte/half of a read word and sign- or
//            zero-extends it according to funct3.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_load_align
    import dmem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rdata,
    input  logic [1:0]      i_addr_lo,
    input  logic [2:0]      i_funct3,
    output logic [XLEN-1:0] o_load_val
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_load_val = i_rdata;
        case (i_funct3)
            F3_B:    o_load_val = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_BU:   o_load_val = {{(XLEN-8){1'b0}}, w_byte};
            F3_H:    o_load_val = {{(XLEN-16){w_half[15]}}, w_half};
            F3_HU:   o_load_val = {{(XLEN-16){1'b0}}, w_half};
            default: o_load_val = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_access_ctrl
// Purpose  : MEM-stage load/store controller: one valid/ready request per
//            instruction, lane steering, load extension, MemStall generation.
//            Optional MISALIGN_TRAP_EN: misaligned ops complete without a request.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   wdata,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_we,
    output logic [ADDR_W-1:0] req_addr,
    output logic [XLEN-1:0]   req_wdata,
    output logic [3:0]        req_wstrb,
    input  logic              rsp_valid,
    input  logic [XLEN-1:0]   rsp_rdata,
    output logic              MemStall,
    output logic [XLEN-1:0]   load_data,
    output logic              misalign
);

    state_t            r_state;
    state_t            w_next;
    logic              w_op;
    logic              w_issue;
    logic              w_trap;
    logic              w_misaligned;
    size_t             w_size;
    logic [3:0]        w_wstrb;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_load_ext;
    logic              r_req_we;
    logic [ADDR_W-1:0] r_req_addr;
    logic [XLEN-1:0]   r_req_wdata;
    logic [3:0]        r_req_wstrb;
    logic [2:0]        r_funct3;
    logic [1:0]        r_addr_lo;
    logic [XLEN-1:0]   r_load_data;

    assign w_op   = MemRead | MemWrite;
    assign w_size = f3_size(funct3);

`ifdef MISALIGN_TRAP_EN
    logic r_misalign;

    always_comb begin
        w_misaligned = 1'b0;
        case (w_size)
            SZ_H:    w_misaligned = addr[0];
            SZ_W:    w_misaligned = |addr[1:0];
            default: w_misaligned = 1'b0;
        endcase
    end

    // Raised only for the DONE cycle that ends a trapped op.
    always_ff @(posedge clk) begin
        if (reset) r_misalign <= 1'b0;
        else       r_misalign <= w_trap;
    end

    assign misalign = r_misalign;
`else
    assign w_misaligned = 1'b0;
    assign misalign     = 1'b0;
`endif

    // Lane steering; halves use addr[1] only and words ignore addr[1:0].
    always_comb begin
        w_wstrb = 4'b1111;
        w_wdata = wdata;
        case (w_size)
            SZ_B: begin
                w_wstrb = 4'b0001 << addr[1:0];
                w_wdata = {4{wdata[7:0]}};
            end
            SZ_H: begin
                w_wstrb = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{wdata[15:0]}};
            end
            default: ;
        endcase
        if (!MemWrite) w_wstrb = 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_issue = 1'b0;
        w_trap  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_op) begin
                    if (w_misaligned) begin
                        w_next = DONE;
                        w_trap = 1'b1;
                    end else begin
                        w_next  = REQ;
                        w_issue = 1'b1;
                    end
                end
            end
            REQ:     if (req_ready) w_next = r_req_we ? DONE : WAIT;
            WAIT:    if (rsp_valid) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // DONE deasserts MemStall so the pipeline moves on exactly once.
    assign MemStall  = ((r_state == IDLE) && w_op) || (r_state == REQ) || (r_state == WAIT);
    assign req_valid = (r_state == REQ);

    lsu_load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .i_rdata    (rsp_rdata),
        .i_addr_lo  (r_addr_lo),
        .i_funct3   (r_funct3),
        .o_load_val (w_load_ext)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_we    <= 1'b0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_req_wstrb <= 4'b0000;
            r_funct3    <= 3'b000;
            r_addr_lo   <= 2'b00;
            r_load_data <= '0;
        end else begin
            if (w_issue) begin
                r_req_we    <= MemWrite;
                r_req_addr  <= {addr[ADDR_W-1:2], 2'b00};
                r_req_wdata <= w_wdata;
                r_req_wstrb <= w_wstrb;
                r_funct3    <= funct3;
                r_addr_lo   <= addr[1:0];
            end
            if ((r_state == WAIT) && rsp_valid) r_load_data <= w_load_ext;
            if (w_trap)                         r_load_data <= '0;
        end
    end

    assign req_we    = r_req_we;
    assign req_addr  = r_req_addr;
    assign req_wdata = r_req_wdata;
    assign req_wstrb = r_req_wstrb;
    assign load_data = r_load_data;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_access_ctrl
// Purpose  : Vector table plus hand sequences for dmem_access_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dmem_access_ctrl;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        MemStall;
    logic [31:0] load_data;
    logic        misalign;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.ADDR_W(32), .XLEN(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .MemStall  (MemStall),
        .load_data (load_data),
        .misalign  (misalign)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          rdy_wait;
        int          rsp_wait;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_load;
        logic        exp_mis;
        int          exp_stall;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs[NVEC];
    vec_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                                input int rw, input int sw, input logic er, input logic [31:0] ea,
                                input logic [31:0] ewd, input logic [3:0] es, input logic [31:0] el,
                                input logic em, input int est);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rdat;
        v.rdy_wait = rw; v.rsp_wait = sw; v.exp_req = er; v.exp_addr = ea;
        v.exp_wdata = ewd; v.exp_wstrb = es; v.exp_load = el; v.exp_mis = em; v.exp_stall = est;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after DONE.
    task automatic run_op(input vec_t v, input string tag);
        vec_t e;
        int   stall = 0;
        int   rcnt = 0;
        int   wcnt = 0;
        bit   in_wait = 0;
        bit   hs;
        bit   done = 0;
        bit   saw_req = 0;
        MemRead = v.rd; MemWrite = v.wr; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
        sbq.push_back(v);
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            hs = 0; req_ready = 0; rsp_valid = 0; rsp_rdata = 32'hBAD0BAD0;
            if (in_wait) begin
                if (wcnt >= v.rsp_wait) begin
                    rsp_valid = 1; rsp_rdata = v.rdata;
                end
                wcnt++;
            end
            if (req_valid) begin
                if (rcnt >= v.rdy_wait) begin
                    req_ready = 1; hs = 1;
                end
                rcnt++;
            end
            #4;
            if (req_valid) begin
                saw_req = 1;
                e = sbq[0];
                chk({tag, " req_addr"}, req_addr, e.exp_addr);
                chk({tag, " req_we"}, {31'd0, req_we}, {31'd0, e.wr});
                chk({tag, " req_wstrb"}, {28'd0, req_wstrb}, {28'd0, e.exp_wstrb});
                if (e.wr) chk({tag, " req_wdata"}, req_wdata, e.exp_wdata);
            end
            if (MemStall) begin
                stall++;
                chk({tag, " misalign_busy"}, {31'd0, misalign}, 32'd0);
            end else begin
                done = 1;
                e = sbq.pop_front();
                chk({tag, " stall_cycles"}, stall, e.exp_stall);
                chk({tag, " req_seen"}, {31'd0, saw_req}, {31'd0, e.exp_req});
                chk({tag, " misalign"}, {31'd0, misalign}, {31'd0, e.exp_mis});
                chk({tag, " req_valid_done"}, {31'd0, req_valid}, 32'd0);
                if (e.rd && !e.wr) chk({tag, " load_data"}, load_data, e.exp_load);
            end
            if (hs && !v.wr) in_wait = 1;
            if (rsp_valid)   in_wait = 0;
            if (!done) begin
                @(posedge clk); #1;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s timeout: no DONE within 64 cycles", tag);
            sbq.delete();
        end
        @(posedge clk); #1;
        MemRead = 0; MemWrite = 0; req_ready = 0; rsp_valid = 0;
    endtask

    initial begin
        vecs[0]  = mk(1, 0, F3_W,   32'h100, 32'h0,        32'hDEADBEEF, 0, 0, 1, 32'h100, 32'h0,        4'h0, 32'hDEADBEEF, 0, 3);
        vecs[1]  = mk(0, 1, F3_B,   32'h203, 32'h000000A5, 32'h0,        0, 0, 1, 32'h200, 32'hA5A5A5A5, 4'h8, 32'h0,        0, 2);
        vecs[2]  = mk(1, 0, F3_B,   32'h101, 32'h0,        32'h00008000, 0, 0, 1, 32'h100, 32'h0,        4'h0, 32'hFFFFFF80, 0, 3);
        vecs[3]  = mk(1, 0, F3_BU,  32'h101, 32'h0,        32'h00008000, 0, 0, 1, 32'h100, 32'h0,        4'h0, 32'h00000080, 0, 3);
        vecs[4]  = mk(0, 1, F3_W,   32'h040, 32'h12345678, 32'h0,        5, 0, 1, 32'h040, 32'h12345678, 4'hF, 32'h0,        0, 7);
        vecs[5]  = mk(0, 1, F3_H,   32'h102, 32'h0000BEEF, 32'h0,        0, 0, 1, 32'h100, 32'hBEEFBEEF, 4'hC, 32'h0,        0, 2);
        vecs[6]  = mk(1, 0, F3_H,   32'h102, 32'h0,        32'h80011234, 0, 2, 1, 32'h100, 32'h0,        4'h0, 32'hFFFF8001, 0, 5);
        vecs[7]  = mk(1, 0, F3_HU,  32'h100, 32'h0,        32'h8001F00D, 0, 0, 1, 32'h100, 32'h0,        4'h0, 32'h0000F00D, 0, 3);
        vecs[8]  = mk(1, 0, F3_B,   32'h103, 32'h0,        32'h7F000000, 0, 0, 1, 32'h100, 32'h0,        4'h0, 32'h0000007F, 0, 3);
        vecs[9]  = mk(1, 0, 3'b011, 32'h010, 32'h0,        32'hCAFEBABE, 0, 0, 1, 32'h010, 32'h0,        4'h0, 32'hCAFEBABE, 0, 3);
        vecs[10] = mk(1, 1, F3_B,   32'h000, 32'h00000011, 32'h0,        0, 0, 1, 32'h000, 32'h11111111, 4'h1, 32'h0,        0, 2);
`ifdef MISALIGN_TRAP_EN
        vecs[11] = mk(1, 0, F3_H,   32'h101, 32'h0,        32'h0000ABCD, 0, 0, 0, 32'h000, 32'h0,        4'h0, 32'h00000000, 1, 1);
`else
        vecs[11] = mk(1, 0, F3_H,   32'h101, 32'h0,        32'h0000ABCD, 0, 0, 1, 32'h100, 32'h0,        4'h0, 32'hFFFFABCD, 0, 3);
`endif
        vecs[12] = mk(1, 0, F3_W,   32'h2FC, 32'h0,        32'h13579BDF, 2, 1, 1, 32'h2FC, 32'h0,        4'h0, 32'h13579BDF, 0, 6);

        reset = 1; MemRead = 0; MemWrite = 0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
        req_ready = 0; rsp_valid = 0; rsp_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #4;
        chk("rst req_valid", {31'd0, req_valid}, 32'd0);
        chk("rst req_we", {31'd0, req_we}, 32'd0);
        chk("rst req_addr", req_addr, 32'd0);
        chk("rst req_wdata", req_wdata, 32'd0);
        chk("rst req_wstrb", {28'd0, req_wstrb}, 32'd0);
        chk("rst load_data", load_data, 32'd0);
        chk("rst misalign", {31'd0, misalign}, 32'd0);
        chk("rst MemStall", {31'd0, MemStall}, 32'd0);
        @(posedge clk); #1;
        reset = 0;
        @(posedge clk); #1;

        // Back-to-back: each op is presented in the cycle right after the prior DONE.
        for (int i = 0; i < NVEC; i++) run_op(vecs[i], $sformatf("v%0d", i));

        // A response outside WAIT must not touch load_data.
        rsp_valid = 1; rsp_rdata = 32'h77777777;
        #4;
        chk("stray MemStall", {31'd0, MemStall}, 32'd0);
        @(posedge clk); #1;
        rsp_valid = 0;
        #4;
        chk("stray load_data", load_data, 32'h13579BDF);
        @(posedge clk); #1;

        // Reset while WAIT, then a late response.
        MemRead = 1; MemWrite = 0; funct3 = F3_W; addr = 32'h300; req_ready = 1;
        @(posedge clk); #1;
        #4;
        chk("rstw req_valid", {31'd0, req_valid}, 32'd1);
        @(posedge clk); #1;
        req_ready = 0; reset = 1;
        #4;
        chk("rstw stall_in_wait", {31'd0, MemStall}, 32'd1);
        @(posedge clk); #1;
        reset = 0; MemRead = 0; rsp_valid = 1; rsp_rdata = 32'h12345678;
        #4;
        chk("rstw req_valid_after", {31'd0, req_valid}, 32'd0);
        chk("rstw MemStall_after", {31'd0, MemStall}, 32'd0);
        chk("rstw load_data_after", load_data, 32'd0);
        @(posedge clk); #1;
        rsp_valid = 0;
        #4;
        chk("rstw load_data_late", load_data, 32'd0);
        chk("rstw MemStall_late", {31'd0, MemStall}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
